clkdiv_cfg_ctrl: RTL and testbench

//  Runtime configuration controller for the programmable frequency divider.

---
 rtl/clkdiv_pkg.sv | 35 +++
 rtl/clkdiv_wdog.sv | 37 +++
 rtl/clkdiv_cfg_ctrl.sv | 143 ++++++++++++++
 tb/tb_clkdiv_cfg_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clock-divider configuration controller.
// Holds the default widths, the controller state encoding and the
// ratio-to-divider conversion used for both reset values and commits.
package clkdiv_pkg;

   localparam int CNT_W_DEF   = 9;
   localparam int RATIO_W_DEF = 10;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   // rat_is_odd sits in the LSB so a size cast to CNT_W+1 bits yields
   // {load_value[CNT_W-1:0], rat_is_odd} directly.
   typedef struct packed {
      logic [31:0] load_value;
      logic        rat_is_odd;
   } cfg_t;

   // A ratio is legal from 2 up to 2**(cnt_w+1) inclusive.
   function automatic logic ratio_ok(input logic [31:0] n, input int cnt_w);
      return (n >= 32'd2) && (n <= (32'd2 << cnt_w));
   endfunction

   // Divider counts floor(N/2) cycles per half period; odd ratios add one
   // cycle to the high phase.
   function automatic cfg_t ratio_to_cfg(input logic [31:0] n);
      cfg_t c;
      c.load_value = (n >> 1) - 32'd1;
      c.rat_is_odd = n[0];
      return c;
   endfunction

endpackage

// File: rtl/clkdiv_wdog.sv
// Edge-activity watchdog for the divider phase output.
// Only present when CLKDIV_CTRL_WDOG_EN is defined; otherwise this file is
// empty so no orphan module exists in the default build.
`ifdef CLKDIV_CTRL_WDOG_EN
module clkdiv_wdog #(
   parameter int WDOG_CYCLES = 1100
) (
   input  logic clkin,
   input  logic rst_n,
   input  logic activity,
   output logic wdog_err
);

   localparam int             W     = $clog2(WDOG_CYCLES + 1);
   localparam logic [W-1:0]   LIMIT = W'(WDOG_CYCLES);

   logic [W-1:0] cnt;

   // Count quiet cycles, restart on any edge, latch the error once the limit is hit.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         wdog_err <= 1'b0;
      end else begin
         if (activity) begin
            cnt <= '0;
         end else if (cnt != LIMIT) begin
            cnt <= cnt + W'(1);
         end
         if (cnt == LIMIT) begin
            wdog_err <= 1'b1;
         end
      end
   end

endmodule
`endif

// File: rtl/clkdiv_cfg_ctrl.sv
// Runtime configuration controller for the programmable clock divider.
// Accepts ratio requests over valid/ready, rejects illegal ratios, and
// commits load_value/rat_is_odd/cur_ratio together on a phase_track rise so
// the divider output never glitches. Reports lock and (optionally) a stuck
// divider. Optional feature macro: CLKDIV_CTRL_WDOG_EN (edge watchdog).
module clkdiv_cfg_ctrl
   import clkdiv_pkg::*;
#(
   parameter int CNT_W         = CNT_W_DEF,
   parameter int RATIO_W       = RATIO_W_DEF,
   parameter int DEFAULT_RATIO = 2,
   parameter int LOCK_PERIODS  = 4,
   parameter int WDOG_CYCLES   = 1100
) (
   input  logic               clkin,
   input  logic               rst_n,
   input  logic               req_valid,
   input  logic [RATIO_W-1:0] req_ratio,
   output logic               req_ready,
   input  logic               phase_track,
   output logic [CNT_W-1:0]   load_value,
   output logic               rat_is_odd,
   output logic [RATIO_W-1:0] cur_ratio,
   output logic               cfg_busy,
   output logic               err_invalid,
   output logic               locked,
   output logic               wdog_err
);

   // Elaboration-time sanity checks on the parameter set.
   if (RATIO_W < CNT_W + 1) begin : g_width_chk
      $error("clkdiv_cfg_ctrl: RATIO_W must be at least CNT_W+1");
   end
   if (LOCK_PERIODS < 1 || WDOG_CYCLES < 2) begin : g_param_chk
      $error("clkdiv_cfg_ctrl: LOCK_PERIODS and WDOG_CYCLES out of range");
   end

   localparam logic [CNT_W:0]   DEF_CFG   = (CNT_W+1)'(ratio_to_cfg(32'(DEFAULT_RATIO)));
   localparam logic [RATIO_W-1:0] DEF_RATIO = RATIO_W'(DEFAULT_RATIO);
   localparam int               LW        = $clog2(LOCK_PERIODS + 1);
   localparam logic [LW-1:0]    LOCK_MAX  = LW'(LOCK_PERIODS);

   state_t             state;
   logic               ph_q;
   logic               rise;
   logic               commit;
   logic [RATIO_W-1:0] pend_ratio;
   logic [CNT_W:0]     pend_cfg;
   logic [LW-1:0]      lock_cnt;

   assign rise     = phase_track & ~ph_q;
   assign commit   = (state == PEND) && rise;
   assign pend_cfg = (CNT_W+1)'(ratio_to_cfg(32'(pend_ratio)));

   // Delayed copy of the divider phase for edge detection.
   // NOTE: every clocked block uses <= so all registers see pre-edge values.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         ph_q <= 1'b0;
      end else begin
         ph_q <= phase_track;
      end
   end

   // Request handshake, validation and rise-aligned commit of the new config.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pend_ratio  <= DEF_RATIO;
         cur_ratio   <= DEF_RATIO;
         load_value  <= DEF_CFG[CNT_W:1];
         rat_is_odd  <= DEF_CFG[0];
         req_ready   <= 1'b1;
         cfg_busy    <= 1'b0;
         err_invalid <= 1'b0;
      end else begin
         // NOTE: default first so err_invalid is a single-cycle pulse on every path.
         err_invalid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  if (ratio_ok(32'(req_ratio), CNT_W)) begin
                     pend_ratio <= req_ratio;
                     state      <= PEND;
                     req_ready  <= 1'b0;
                     cfg_busy   <= 1'b1;
                  end else begin
                     err_invalid <= 1'b1;
                  end
               end
            end
            PEND: begin
               // A rise in the acceptance cycle was seen while still IDLE,
               // so the first rise acted on here is always a fresh one.
               if (rise) begin
                  load_value <= pend_cfg[CNT_W:1];
                  rat_is_odd <= pend_cfg[0];
                  cur_ratio  <= pend_ratio;
                  state      <= IDLE;
                  req_ready  <= 1'b1;
                  cfg_busy   <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               cfg_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Count clean output periods since the last commit; saturate at LOCK_PERIODS.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (commit) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (rise && (lock_cnt != LOCK_MAX)) begin
         lock_cnt <= lock_cnt + LW'(1);
         locked   <= (lock_cnt == LOCK_MAX - LW'(1));
      end
   end

`ifdef CLKDIV_CTRL_WDOG_EN
   logic ph_edge;
   assign ph_edge = phase_track ^ ph_q;

   clkdiv_wdog #(
      .WDOG_CYCLES(WDOG_CYCLES)
   ) u_wdog (
      .clkin    (clkin),
      .rst_n    (rst_n),
      .activity (ph_edge),
      .wdog_err (wdog_err)
   );
`else
   assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Bench for clkdiv_cfg_ctrl paired with a behavioural divider.
// Stimulus pushes the expected commit/reject into a queue; a monitor pops
// and compares whenever the DUT reports a commit (cfg_busy falls) or a
// rejection (err_invalid). Period/duty/lock/latency are checked directly.
// RATIO_W is widened to 11 so 1024 (largest legal) and 1025 are representable.
module tb_clkdiv_cfg_ctrl;

   localparam int CNT_W     = 9;
   localparam int RATIO_W   = 11;
   localparam int EV_COMMIT = 0;
   localparam int EV_ERR    = 1;

   typedef struct {
      int kind;
      int ratio;
      int load;
      int odd;
   } exp_t;

   logic               clkin;
   logic               rst_n;
   logic               req_valid;
   logic [RATIO_W-1:0] req_ratio;
   logic               req_ready;
   logic               phase_track;
   logic [CNT_W-1:0]   load_value;
   logic               rat_is_odd;
   logic [RATIO_W-1:0] cur_ratio;
   logic               cfg_busy;
   logic               err_invalid;
   logic               locked;
   logic               wdog_err;

   exp_t exp_q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   model_ratio = 2;
   int   xfer_cyc = 0;

   // Divider model and measurement state
   logic             div_q;
   logic [CNT_W-1:0] div_cnt;
   logic             stuck;
   logic             div_prev = 1'b0;
   logic             rise_now = 1'b0;
   logic             busy_q = 1'b0;
   int               rise_cnt = 0;
   int               last_rise = 0;
   int               last_period = 0;
   int               last_high = 0;

   clkdiv_cfg_ctrl #(
      .CNT_W   (CNT_W),
      .RATIO_W (RATIO_W)
   ) dut (
      .clkin       (clkin),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ratio   (req_ratio),
      .req_ready   (req_ready),
      .phase_track (phase_track),
      .load_value  (load_value),
      .rat_is_odd  (rat_is_odd),
      .cur_ratio   (cur_ratio),
      .cfg_busy    (cfg_busy),
      .err_invalid (err_invalid),
      .locked      (locked),
      .wdog_err    (wdog_err)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   always @(posedge clkin) cyc <= cyc + 1;

   // Divider: high phase load+odd+1 cycles, low phase load+1 cycles.
   always @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= 1'b0;
         div_cnt <= '0;
      end else if (div_cnt == '0) begin
         div_q   <= ~div_q;
         div_cnt <= div_q ? load_value : load_value + CNT_W'(rat_is_odd);
      end else begin
         div_cnt <= div_cnt - CNT_W'(1);
      end
   end

   assign phase_track = stuck ? 1'b0 : div_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Period/duty measurement and scoreboard monitor, both at the falling edge.
   always @(negedge clkin) begin
      rise_now = div_q && !div_prev;
      if (rise_now) begin
         last_period = cyc - last_rise;
         last_rise   = cyc;
         rise_cnt++;
      end
      if (!div_q && div_prev) last_high = cyc - last_rise;
      div_prev = div_q;

      if (!rst_n) begin
         busy_q = 1'b0;
      end else begin
         if (err_invalid) begin
            check("sb_err_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("sb_err_kind", e.kind, EV_ERR);
               check("sb_err_cur_ratio", 32'(cur_ratio), e.ratio);
            end
         end
         if (busy_q && !cfg_busy) begin
            check("sb_commit_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("sb_commit_kind", e.kind, EV_COMMIT);
               check("sb_commit_cur_ratio", 32'(cur_ratio), e.ratio);
               check("sb_commit_load", 32'(load_value), e.load);
               check("sb_commit_odd", 32'(rat_is_odd), e.odd);
            end
         end
         busy_q = cfg_busy;
      end
   end

   // Sample point: just after the falling edge, after the monitor has run.
   task automatic tick();
      @(negedge clkin);
      #1;
   endtask

   task automatic wait_ready(output bit ok);
      int n = 0;
      while (!req_ready && n < 3000) begin
         tick();
         n++;
      end
      ok = req_ready;
      if (!ok) check("timeout_req_ready", 0, 1);
   endtask

   task automatic do_transfer(input bit hold);
      @(posedge clkin);
      #1;
      xfer_cyc = cyc;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic send_ok(input int r, input int exp_load, input int exp_odd, input bit hold);
      bit ok;
      logic [31:0] rv;
      rv        = 32'(r);
      req_valid = 1'b1;
      req_ratio = rv[RATIO_W-1:0];
      wait_ready(ok);
      if (ok) begin
         exp_q.push_back('{EV_COMMIT, r, exp_load, exp_odd});
         model_ratio = r;
         do_transfer(hold);
      end else begin
         req_valid = 1'b0;
      end
   endtask

   task automatic send_bad(input int r);
      bit ok;
      logic [31:0] rv;
      rv        = 32'(r);
      req_valid = 1'b1;
      req_ratio = rv[RATIO_W-1:0];
      wait_ready(ok);
      if (ok) begin
         exp_q.push_back('{EV_ERR, model_ratio, 0, 0});
         do_transfer(1'b0);
      end else begin
         req_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (cfg_busy && n < 3000) begin
         tick();
         n++;
      end
      if (cfg_busy) check("timeout_commit", 0, 1);
   endtask

   task automatic wait_rises(input int k);
      int target = rise_cnt + k;
      int n = 0;
      while (rise_cnt < target && n < 5000) begin
         tick();
         n++;
      end
      if (rise_cnt < target) check("timeout_rise", 0, 1);
   endtask

   task automatic wait_rise_cycle();
      int n = 0;
      tick();
      while (!rise_now && n < 3000) begin
         tick();
         n++;
      end
      if (!rise_now) check("timeout_rise_cycle", 0, 1);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_ratio = '0;
      stuck     = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_cur_ratio", 32'(cur_ratio), 2);
      check("rst_load", 32'(load_value), 0);
      check("rst_odd", 32'(rat_is_odd), 0);
      check("rst_ready", 32'(req_ready), 1);
      check("rst_busy", 32'(cfg_busy), 0);
      check("rst_err", 32'(err_invalid), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_wdog", 32'(wdog_err), 0);

      // Default ratio 2 and lock after 4 periods
      rst_n = 1'b1;
      wait_rises(2);
      check("n2_locked_early", 32'(locked), 0);
      check("n2_period", last_period, 2);
      check("n2_high", last_high, 1);
      wait_rises(4);
      check("n2_locked", 32'(locked), 1);

      // N=7 while running N=2
      send_ok(7, 2, 1, 1'b0);
      wait_idle();
      check("n7_lock_cleared", 32'(locked), 0);
      check("n7_latency_le_3", 32'((cyc - xfer_cyc) <= 3), 1);
      wait_rises(3);
      check("n7_period", last_period, 7);
      check("n7_high", last_high, 4);

      // Illegal ratios
      send_bad(1);
      tick();
      check("bad1_ready", 32'(req_ready), 1);
      check("bad1_err_pulse", 32'(err_invalid), 1);
      tick();
      check("bad1_err_one_cycle", 32'(err_invalid), 0);
      send_bad(1025);
      tick();
      check("bad1025_ready", 32'(req_ready), 1);
      send_bad(0);
      tick();
      check("bad_cur_ratio", 32'(cur_ratio), 7);
      check("bad_load", 32'(load_value), 2);

      // Request accepted in a rise cycle: that rise is ignored
      wait_rise_cycle();
      send_ok(3, 0, 1, 1'b0);
      tick();
      check("rise_acc_busy", 32'(cfg_busy), 1);
      wait_idle();
      check("rise_acc_delay", cyc - xfer_cyc, 7);
      wait_rises(3);
      check("n3_period", last_period, 3);
      check("n3_high", last_high, 2);

      // Back-to-back with req_valid held
      send_ok(10, 4, 0, 1'b1);
      tick();
      check("b2b_ready_low", 32'(req_ready), 0);
      check("b2b_busy", 32'(cfg_busy), 1);
      send_ok(4, 1, 0, 1'b0);
      check("b2b_first_committed", 32'(cur_ratio), 10);
      wait_idle();
      wait_rises(3);
      check("n4_period", last_period, 4);
      check("n4_high", last_high, 2);

      // Same ratio again still commits and clears lock
      wait_rises(6);
      check("n4_locked", 32'(locked), 1);
      send_ok(4, 1, 0, 1'b0);
      wait_idle();
      check("same_ratio_lock_cleared", 32'(locked), 0);

      // Largest legal ratio
      send_ok(1024, 511, 0, 1'b0);
      wait_idle();
      wait_rises(2);
      check("n1024_period", last_period, 1024);
      check("n1024_high", last_high, 512);

      // Reset while a request is pending
      wait_rise_cycle();
      send_ok(5, 1, 1, 1'b0);
      repeat (3) tick();
      check("pend_busy", 32'(cfg_busy), 1);
      rst_n = 1'b0;
      exp_q.delete();
      model_ratio = 2;
      tick();
      check("pend_rst_cur_ratio", 32'(cur_ratio), 2);
      check("pend_rst_load", 32'(load_value), 0);
      check("pend_rst_odd", 32'(rat_is_odd), 0);
      check("pend_rst_busy", 32'(cfg_busy), 0);
      check("pend_rst_ready", 32'(req_ready), 1);
      rst_n = 1'b1;
      wait_rises(3);
      check("pend_rst_period", last_period, 2);
      check("pend_rst_no_commit", 32'(cur_ratio), 2);

`ifdef CLKDIV_CTRL_WDOG_EN
      // Stuck divider output
      stuck = 1'b1;
      repeat (1050) tick();
      check("wdog_not_yet", 32'(wdog_err), 0);
      repeat (60) tick();
      check("wdog_set", 32'(wdog_err), 1);
      stuck = 1'b0;
      repeat (20) tick();
      check("wdog_sticky", 32'(wdog_err), 1);
`else
      check("wdog_tied_low", 32'(wdog_err), 0);
`endif

      tick();
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
